apb_slave_mem: RTL and testbench
================================

Name: apb_slave_mem

Overview:
- Parametrised APB4 slave responder and memory model for the AHB-to-APB bridge environment.
- Replaces the fixed, testbench-driven slave response with a synthesizable target that has:
  - a word-addressed register array with PSTRB byte writes
  - programmable wait states
  - PSLVERR generation for decode, alignment and protection faults
  - a sticky flag for master protocol violations
- Sits on the APB side of the bridge as the device under access; the scoreboard reads its memory through the normal APB read path.

Parameters:
- PDATA_SIZE, 32, APB data width in bits; must be 8, 16, 32 or 64.
- PADDR_SIZE, 32, APB address width in bits.
- DEPTH, 16, number of PDATA_SIZE-wide words; power of two, 2 to 256.
- BASE_ADDR, 0, byte address of word 0; aligned to DEPTH*PDATA_SIZE/8.
- MAX_WAIT, 15, largest legal WAIT_CFG value; WAIT_CFG is clamped to this.
- PROT_CHECK, 1, when 1, writes with PPROT[0]=0 (unprivileged) are rejected.

Ports:
- PCLK  in  1  APB clock; all state changes on its rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  PADDR_SIZE  byte address.
- PWDATA  in  PDATA_SIZE  write data.
- PSTRB  in  PDATA_SIZE/8  write byte strobes.
- PPROT  in  3  protection attributes.
- WAIT_CFG  in  8  wait states inserted per transfer; sampled in the setup phase.
- PRDATA  out  PDATA_SIZE  read data; registered.
- PREADY  out  1  transfer-complete indicator; registered.
- PSLVERR  out  1  error response; registered.
- PROT_VIOL  out  1  sticky flag for master protocol violation.
- VIOL_CLR  in  1  synchronous clear for PROT_VIOL.

Behaviour:
- Reset (PRESET=1, asynchronous):
  - State goes to IDLE.
  - PRDATA, PREADY, PSLVERR, PROT_VIOL and the wait counter go to 0.
  - All memory words are cleared to 0.
  - A transfer in progress is aborted with no memory update.
- States: IDLE, ACCESS.
- IDLE:
  - PREADY=0.
  - On a sampled setup phase (PSEL=1, PENABLE=0), latch PADDR, PWRITE, PWDATA, PSTRB and PPROT, then go to ACCESS.
  - Load cnt = min(WAIT_CFG, MAX_WAIT).
  - Set PREADY <= (cnt==0), so a zero-wait transfer completes in the first access cycle.
- ACCESS with PREADY=0:
  - Decrement cnt each cycle.
  - When cnt reaches 1, PREADY <= 1.
  - Total access cycles = wait + 1.
- ACCESS with PREADY=1 and PSEL=PENABLE=1 sampled (completion edge):
  - Commit the write if there is no error.
  - PREADY <= 0 and PSLVERR <= 0 at that edge; return to IDLE.
  - The next transfer needs a new setup phase; a setup in the same cycle as completion is not accepted.
- PRDATA and PSLVERR are loaded on the edge that sets PREADY:
  - They are valid only while PREADY=1.
  - PSLVERR is otherwise 0.
  - PRDATA holds its last value outside transfers.
- Error conditions; any one sets PSLVERR=1 with PREADY:
  - Decode: (PADDR - BASE_ADDR) >> log2(PDATA_SIZE/8) ≥ DEPTH, or PADDR < BASE_ADDR.
  - Alignment: PADDR[log2(PDATA_SIZE/8)-1:0] ≠ 0.
  - Protection: PROT_CHECK=1, PWRITE=1 and PPROT[0]=0.
- On an errored write, memory is unchanged. On an errored read, PRDATA=0.
- Write commit: for each byte lane i with PSTRB[i]=1, mem[idx][8i+7:8i] <= latched PWDATA lane i; lanes with PSTRB[i]=0 are kept. PSTRB=0 is a legal no-op write with PSLVERR=0.
- Read: PRDATA <= mem[idx]. PSTRB is ignored on reads.
- Protocol violation in ACCESS: any of the following sets PROT_VIOL=1, drops PREADY and PSLVERR to 0, returns to IDLE, and commits nothing:
  - PSEL=0
  - PENABLE=0
  - PADDR, PWRITE or PWDATA differs from the latched value
- PROT_VIOL holds until VIOL_CLR=1 or reset. If VIOL_CLR=1 and a new violation occur in the same cycle, set wins.
- WAIT_CFG changing mid-transfer has no effect on that transfer.

Test Plan:
- Reset mid-write: assert PRESET during the ACCESS wait of a write to 0x8 with PWDATA=0xDEADBEEF, WAIT_CFG=3 -> PREADY=0 immediately; a later read of 0x8 returns 0x00000000 with PSLVERR=0.
- Zero-wait write then read: write 0x4 data 0x12345678 with PSTRB=0xF, WAIT_CFG=0 -> PREADY in the first access cycle; read 0x4 -> PRDATA=0x12345678, PSLVERR=0, 2 cycles per transfer.
- Byte strobes and wait states: write 0x4 data 0xAABBCCDD with PSTRB=0x5, WAIT_CFG=3 -> PREADY after 4 access cycles; read 0x4 -> 0x12BB56DD.
- Error responses:
  - read 0x40 (DEPTH=16) -> PSLVERR=1, PRDATA=0
  - write 0x6 -> PSLVERR=1
  - write 0x0 with PPROT=3'b000 -> PSLVERR=1, mem[0] unchanged
- Protocol violation: drop PSEL during the second wait cycle of a write to 0xC -> PROT_VIOL=1, mem[3] unchanged; pulse VIOL_CLR -> PROT_VIOL=0 next cycle.
- Clamp: WAIT_CFG=200 with MAX_WAIT=15 -> PREADY after exactly 16 access cycles.

Source files
------------

// File: rtl/apb_slave_mem.sv
// APB4 slave with a word-addressed memory, byte strobes, programmable wait states,
// error responses for decode/alignment/protection faults and a sticky protocol-violation flag.
module apb_slave_mem #(
    parameter int                    PDATA_SIZE = 32,
    parameter int                    PADDR_SIZE = 32,
    parameter int                    DEPTH      = 16,
    parameter logic [PADDR_SIZE-1:0] BASE_ADDR  = '0,
    parameter int                    MAX_WAIT   = 15,
    parameter int                    PROT_CHECK = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    input  logic [7:0]              WAIT_CFG,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic                    PROT_VIOL,
    input  logic                    VIOL_CLR,
    output logic                    dbg_state_o
);

    localparam int NB    = PDATA_SIZE / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [PADDR_SIZE-1:0] ALIGN_MASK = PADDR_SIZE'(NB - 1);
    localparam logic [7:0]            MAX_WAIT_C = 8'(MAX_WAIT);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [PADDR_SIZE-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [PDATA_SIZE-1:0]   wdata_q, wdata_d;
    logic [NB-1:0]           strb_q, strb_d;
    logic                    priv_q, priv_d;
    logic [PDATA_SIZE-1:0]   prdata_q, prdata_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic                    viol_q, viol_d;
    logic [PDATA_SIZE-1:0]   mem_q [DEPTH];

    logic                    setup;
    logic                    viol_now;
    logic                    err_setup, err_lat;
    logic [IDX_W-1:0]        idx_setup, idx_lat;
    logic [7:0]              wait_clamped;
    logic                    mem_we;
    logic [PDATA_SIZE-1:0]   mem_wdata;
    logic                    unused_prot;

    // Underflow below BASE_ADDR shows up as the borrow bit of the widened subtraction.
    function automatic logic addr_err(input logic [PADDR_SIZE-1:0] a);
        logic [PADDR_SIZE:0] off;
        off = {1'b0, a} - {1'b0, BASE_ADDR};
        return off[PADDR_SIZE]
            || ((off[PADDR_SIZE-1:0] >> LSB) >= PADDR_SIZE'(DEPTH))
            || ((a & ALIGN_MASK) != '0);
    endfunction

    function automatic logic access_err(input logic [PADDR_SIZE-1:0] a, input logic wr,
                                        input logic priv);
        return addr_err(a) || ((PROT_CHECK != 0) && wr && !priv);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [PADDR_SIZE-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> LSB);
    endfunction

    assign unused_prot  = ^PPROT[2:1];
    assign setup        = PSEL && !PENABLE;
    assign err_setup    = access_err(PADDR, PWRITE, PPROT[0]);
    assign err_lat      = access_err(addr_q, write_q, priv_q);
    assign idx_setup    = word_idx(PADDR);
    assign idx_lat      = word_idx(addr_q);
    assign wait_clamped = (WAIT_CFG > MAX_WAIT_C) ? MAX_WAIT_C : WAIT_CFG;
    assign viol_now     = (state_q == S_ACCESS)
                        && (!PSEL || !PENABLE || (PADDR != addr_q)
                            || (PWRITE != write_q) || (PWDATA != wdata_q));

    always_comb begin
        mem_wdata = mem_q[idx_lat];
        for (int i = 0; i < NB; i++) begin
            if (strb_q[i]) mem_wdata[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (setup) state_d = S_ACCESS;
            S_ACCESS: if (viol_now || pready_q) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Violations take priority over both completion and the wait countdown.
    always_comb begin
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        priv_d    = priv_q;
        prdata_d  = prdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        viol_d    = VIOL_CLR ? 1'b0 : viol_q;
        mem_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                pready_d = 1'b0;
                if (setup) begin
                    addr_d  = PADDR;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    strb_d  = PSTRB;
                    priv_d  = PPROT[0];
                    cnt_d   = wait_clamped;
                    if (wait_clamped == 8'd0) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_setup;
                        if (!PWRITE) prdata_d = err_setup ? '0 : mem_q[idx_setup];
                    end
                end
            end
            S_ACCESS: begin
                if (viol_now) begin
                    viol_d    = 1'b1;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    cnt_d     = 8'd0;
                end else if (pready_q) begin
                    mem_we    = write_q && !pslverr_q;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_lat;
                        if (!write_q) prdata_d = err_lat ? '0 : mem_q[idx_lat];
                    end
                end
            end
            default: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            strb_q    <= '0;
            priv_q    <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            viol_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            priv_q    <= priv_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            viol_q    <= viol_d;
            if (mem_we) mem_q[idx_lat] <= mem_wdata;
        end
    end

    assign PRDATA      = prdata_q;
    assign PREADY      = pready_q;
    assign PSLVERR     = pslverr_q;
    assign PROT_VIOL   = viol_q;
    assign dbg_state_o = (state_q == S_ACCESS);

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: directed vector table, randomized transfers against a
// word-array reference model, and hand-driven reset / protocol-violation sequences.
module tb_apb_slave_mem;

    localparam int DEPTH = 16;
    localparam int MAXW  = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite, vclr;
    logic [31:0] paddr, pwdata, prdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [7:0]  wait_cfg;
    logic        pready, pslverr, prot_viol, dbg_state;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_m [DEPTH];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [7:0]  cfg;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } vec_t;

    vec_t vecs[14];

    apb_slave_mem dut (
        .PCLK(clk), .PRESET(rst), .PSEL(psel), .PENABLE(penable), .PWRITE(pwrite),
        .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot), .WAIT_CFG(wait_cfg),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr), .PROT_VIOL(prot_viol),
        .VIOL_CLR(vclr), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: memory is a plain word array; timing is clamp(cfg)+1 access cycles.
    function automatic void model_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                                       input logic [3:0] strb, input logic [2:0] prot, input logic [7:0] cfg,
                                       output logic [31:0] rdata, output logic err, output int cycles);
        int idx;
        err    = (addr >= 32'(DEPTH * 4)) || (addr % 4 != 0) || (wr && !prot[0]);
        idx    = int'(addr / 4);
        cycles = ((int'(cfg) > MAXW) ? MAXW : int'(cfg)) + 1;
        rdata  = 32'h0;
        if (!err) begin
            if (wr) begin
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) mem_m[idx][8*b +: 8] = data[8*b +: 8];
                end
            end else begin
                rdata = mem_m[idx];
            end
        end
    endfunction

    // Called #1 after a rising edge; returns #1 after the completion edge.
    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [2:0] prot, input logic [7:0] cfg,
                            input bit scramble_cfg,
                            output logic [31:0] rdata, output logic err, output int cycles);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
        pwdata = data; pstrb = strb; pprot = prot; wait_cfg = cfg;
        @(posedge clk); #1;
        penable = 1'b1;
        if (scramble_cfg) wait_cfg = 8'($urandom_range(0, 255));
        cycles = 1;
        while (pready !== 1'b1 && cycles < 40) begin
            @(posedge clk); #1;
            cycles++;
        end
        rdata = prdata;
        err   = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        checks++;
        if (pready !== 1'b0 || pslverr !== 1'b0) begin
            errors++;
            $display("FAIL post_complete: got pready=%b pslverr=%b expected 0 0", pready, pslverr);
        end
    endtask

    task automatic run_checked(input string tag, input logic wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                               input logic [7:0] cfg, input bit scramble);
        logic [31:0] exp_rd, act_rd;
        logic        exp_err, act_err;
        int          exp_cyc, act_cyc;
        model_xfer(wr, addr, data, strb, prot, cfg, exp_rd, exp_err, exp_cyc);
        apb_xfer(wr, addr, data, strb, prot, cfg, scramble, act_rd, act_err, act_cyc);
        check({tag, "_err"}, 64'(act_err), 64'(exp_err));
        check({tag, "_cyc"}, 64'(act_cyc), 64'(exp_cyc));
        if (!wr) check({tag, "_rdata"}, 64'(act_rd), 64'(exp_rd));
    endtask

    initial begin
        logic [31:0] rd, a, d;
        logic        er;
        int          cy;
        logic        wr;
        logic [2:0]  pr;
        logic [7:0]  cf;

        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; vclr = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b001; wait_cfg = '0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pready", 64'(pready), 64'd0);
        check("rst_pslverr", 64'(pslverr), 64'd0);
        check("rst_prot_viol", 64'(prot_viol), 64'd0);
        check("rst_prdata", 64'(prdata), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        vecs[0]  = '{1'b1, 32'h04, 32'h12345678, 4'hF, 3'b001, 8'd0,   32'h0,        1'b0, 1};
        vecs[1]  = '{1'b0, 32'h04, 32'h0,        4'h0, 3'b001, 8'd0,   32'h12345678, 1'b0, 1};
        vecs[2]  = '{1'b1, 32'h04, 32'hAABBCCDD, 4'h5, 3'b001, 8'd3,   32'h0,        1'b0, 4};
        vecs[3]  = '{1'b0, 32'h04, 32'h0,        4'hF, 3'b001, 8'd0,   32'h12BB56DD, 1'b0, 1};
        vecs[4]  = '{1'b0, 32'h40, 32'h0,        4'h0, 3'b001, 8'd0,   32'h0,        1'b1, 1};
        vecs[5]  = '{1'b1, 32'h06, 32'h11111111, 4'hF, 3'b001, 8'd1,   32'h0,        1'b1, 2};
        vecs[6]  = '{1'b1, 32'h00, 32'hFFFFFFFF, 4'hF, 3'b000, 8'd0,   32'h0,        1'b1, 1};
        vecs[7]  = '{1'b0, 32'h00, 32'h0,        4'h0, 3'b000, 8'd0,   32'h0,        1'b0, 1};
        vecs[8]  = '{1'b1, 32'h00, 32'hCAFE0001, 4'h0, 3'b001, 8'd0,   32'h0,        1'b0, 1};
        vecs[9]  = '{1'b0, 32'h00, 32'h0,        4'h0, 3'b001, 8'd2,   32'h0,        1'b0, 3};
        vecs[10] = '{1'b1, 32'h3C, 32'h55AA55AA, 4'hF, 3'b011, 8'd200, 32'h0,        1'b0, 16};
        vecs[11] = '{1'b0, 32'h3C, 32'h0,        4'h0, 3'b001, 8'd2,   32'h55AA55AA, 1'b0, 3};
        vecs[12] = '{1'b0, 32'h02, 32'h0,        4'h0, 3'b001, 8'd0,   32'h0,        1'b1, 1};
        vecs[13] = '{1'b1, 32'h40, 32'h77777777, 4'hF, 3'b111, 8'd0,   32'h0,        1'b1, 1};

        foreach (vecs[i]) begin
            logic [31:0] m_rd;
            logic        m_er;
            int          m_cy;
            model_xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].prot,
                       vecs[i].cfg, m_rd, m_er, m_cy);
            apb_xfer(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].prot,
                     vecs[i].cfg, 1'b0, rd, er, cy);
            check($sformatf("vec%0d_err", i), 64'(er), 64'(vecs[i].err));
            check($sformatf("vec%0d_cyc", i), 64'(cy), 64'(vecs[i].cyc));
            if (!vecs[i].wr) check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].rdata));
        end

        for (int n = 0; n < 60; n++) begin
            wr = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0:       a = 32'($urandom_range(64, 400));
                1:       a = 32'($urandom_range(0, 63)) | 32'h1;
                2:       a = 32'hFFFF_FFF0;
                default: a = 32'($urandom_range(0, DEPTH - 1)) << 2;
            endcase
            d  = $urandom;
            pr = ($urandom_range(0, 5) == 0) ? 3'b000 : (3'($urandom_range(0, 7)) | 3'b001);
            cf = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(16, 255)) : 8'($urandom_range(0, 4));
            run_checked($sformatf("rnd%0d", n), wr, a, d, 4'($urandom_range(0, 15)), pr, cf, 1'b1);
        end

        // Dropping PSEL in the second wait cycle aborts the write and raises the flag.
        run_checked("viol_pre", 1'b1, 32'h0C, 32'h0C0C0C0C, 4'hF, 3'b001, 8'd0, 1'b0);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C;
        pwdata = 32'hBAD0BAD0; pstrb = 4'hF; pprot = 3'b001; wait_cfg = 8'd3;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        check("viol_state_access", 64'(dbg_state), 64'd1);
        psel = 1'b0;
        @(posedge clk); #1;
        check("viol_set", 64'(prot_viol), 64'd1);
        check("viol_pready", 64'(pready), 64'd0);
        check("viol_state_idle", 64'(dbg_state), 64'd0);
        penable = 1'b0;
        @(posedge clk); #1;
        check("viol_sticky", 64'(prot_viol), 64'd1);
        vclr = 1'b1;
        @(posedge clk); #1;
        vclr = 1'b0;
        check("viol_clear", 64'(prot_viol), 64'd0);
        run_checked("viol_mem", 1'b0, 32'h0C, 32'h0, 4'h0, 3'b001, 8'd0, 1'b0);

        // Write data changing mid-access while VIOL_CLR is high: set must win.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10;
        pwdata = 32'h01020304; pstrb = 4'hF; pprot = 3'b001; wait_cfg = 8'd2;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        pwdata = 32'hFEFEFEFE; vclr = 1'b1;
        @(posedge clk); #1;
        check("viol_set_wins", 64'(prot_viol), 64'd1);
        check("viol_set_wins_pready", 64'(pready), 64'd0);
        vclr = 1'b0; psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1;
        vclr = 1'b1;
        @(posedge clk); #1;
        vclr = 1'b0;
        check("viol_clear2", 64'(prot_viol), 64'd0);
        run_checked("viol_mem2", 1'b0, 32'h10, 32'h0, 4'h0, 3'b001, 8'd0, 1'b0);

        // Asynchronous reset while a WAIT_CFG=3 write to 0x8 is in its access phase.
        run_checked("rstw_pre", 1'b1, 32'h08, 32'h11112222, 4'hF, 3'b001, 8'd0, 1'b0);
        run_checked("rstw_pre_rd", 1'b0, 32'h08, 32'h0, 4'h0, 3'b001, 8'd0, 1'b0);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h08;
        pwdata = 32'hDEADBEEF; pstrb = 4'hF; pprot = 3'b001; wait_cfg = 8'd3;
        @(posedge clk); #1;
        penable = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("rstw_pready_before", 64'(pready), 64'd1);
        rst = 1'b1;
        #1;
        check("rstw_pready_async", 64'(pready), 64'd0);
        check("rstw_prdata", 64'(prdata), 64'd0);
        psel = 1'b0; penable = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_checked("rstw_rd8", 1'b0, 32'h08, 32'h0, 4'h0, 3'b001, 8'd0, 1'b0);
        run_checked("rstw_rd4", 1'b0, 32'h04, 32'h0, 4'h0, 3'b001, 8'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
